// File: rtl/button_bounce_gen.sv
// -----------------------------------------------------------------------------
// button_bounce_gen
//
// Purpose:
//   Emulates a mechanical push-button with contact bounce. Each press or
//   release request produces a burst of alternating glitch segments, starting
//   at the target level. The burst is followed by a stable settle period at the
//   target level, and then a one-cycle done pulse.
//
// Ports:
//   clk_i          system clock; all logic runs on the rising edge
//   reset_i        asynchronous, active-high reset
//   press_req_i    one-cycle request for a bouncy press (accepted in IDLE_LOW)
//   release_req_i  one-cycle request for a bouncy release (accepted in HELD_HIGH)
//   btn_o          registered raw button level, for feeding a debouncer
//   busy_o         high while a bounce/settle sequence is in progress
//   done_o         one-cycle pulse in the cycle that busy_o falls
//   held_o         settled button level (0 released, 1 pressed)
//
// Configuration:
//   BOUNCE_RANDOM_EN  When defined, the width of each segment is taken from a
//                     16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1). The LFSR
//                     steps at every segment start, and W = LFSR[GLITCH_BITS-1:0]+1.
//                     When undefined, every segment is GLITCH_W cycles wide and
//                     no LFSR is built.
//
// Timing:
//   The outputs are registered copies of values decoded from the current
//   state. A request sampled at edge k therefore first shows on btn_o in
//   cycle k+1.
// -----------------------------------------------------------------------------
module button_bounce_gen #(
    parameter int          BOUNCE_COUNT  = 6,
    parameter int          GLITCH_W      = 3,
    parameter int          GLITCH_BITS   = 5,
    parameter int          SETTLE_CYCLES = 2000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic press_req_i,
    input  logic release_req_i,
    output logic btn_o,
    output logic busy_o,
    output logic done_o,
    output logic held_o
);

    typedef enum logic [2:0] {
        IDLE_LOW,
        BOUNCE_RISE,
        SETTLE_RISE,
        HELD_HIGH,
        BOUNCE_FALL,
        SETTLE_FALL
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  seg_cnt_q, seg_cnt_d;       // cycles elapsed in current segment
    logic [3:0]  pair_cnt_q, pair_cnt_d;     // glitch pair index
    logic        phase_q, phase_d;           // 0: target-level half, 1: opposite half
    logic [13:0] settle_cnt_q, settle_cnt_d;
    logic        btn_q, btn_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        held_q, held_d;
    logic        seg_start;                  // a new segment begins at the next edge
    logic [4:0]  w_m1;                       // current segment width minus one

`ifdef BOUNCE_RANDOM_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;
    logic [15:0] w_mask;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_d  = seg_start ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
    assign w_mask  = 16'((32'd1 << GLITCH_BITS) - 32'd1);
    // The LFSR already holds the stepped value during the segment it sizes.
    assign w_m1    = 5'(lfsr_q & w_mask);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign w_m1 = 5'(GLITCH_W - 1);
`endif

    // Next-state and counter logic
    always_comb begin
        state_d      = state_q;
        seg_cnt_d    = seg_cnt_q;
        pair_cnt_d   = pair_cnt_q;
        phase_d      = phase_q;
        settle_cnt_d = settle_cnt_q;
        seg_start    = 1'b0;

        case (state_q)
            IDLE_LOW: begin
                if (press_req_i) begin
                    state_d    = BOUNCE_RISE;
                    seg_cnt_d  = '0;
                    pair_cnt_d = '0;
                    phase_d    = 1'b0;
                    seg_start  = 1'b1;
                end
            end
            HELD_HIGH: begin
                if (release_req_i) begin
                    state_d    = BOUNCE_FALL;
                    seg_cnt_d  = '0;
                    pair_cnt_d = '0;
                    phase_d    = 1'b0;
                    seg_start  = 1'b1;
                end
            end
            BOUNCE_RISE, BOUNCE_FALL: begin
                if (seg_cnt_q == w_m1) begin
                    seg_cnt_d = '0;
                    if (!phase_q) begin
                        phase_d   = 1'b1;
                        seg_start = 1'b1;
                    end else if (pair_cnt_q == 4'(BOUNCE_COUNT - 1)) begin
                        // Last segment done: hold the target level for the settle period.
                        phase_d      = 1'b0;
                        pair_cnt_d   = '0;
                        settle_cnt_d = '0;
                        state_d      = (state_q == BOUNCE_RISE) ? SETTLE_RISE : SETTLE_FALL;
                    end else begin
                        phase_d    = 1'b0;
                        pair_cnt_d = pair_cnt_q + 4'd1;
                        seg_start  = 1'b1;
                    end
                end else begin
                    seg_cnt_d = seg_cnt_q + 5'd1;
                end
            end
            SETTLE_RISE, SETTLE_FALL: begin
                if (settle_cnt_q == 14'(SETTLE_CYCLES - 1)) begin
                    settle_cnt_d = '0;
                    state_d      = (state_q == SETTLE_RISE) ? HELD_HIGH : IDLE_LOW;
                end else begin
                    settle_cnt_d = settle_cnt_q + 14'd1;
                end
            end
            default: state_d = IDLE_LOW;
        endcase
    end

    // Output decode. These values are registered, so they trail the state by one cycle.
    always_comb begin
        btn_d = 1'b0;
        case (state_q)
            IDLE_LOW:    btn_d = 1'b0;
            BOUNCE_RISE: btn_d = ~phase_q;
            SETTLE_RISE: btn_d = 1'b1;
            HELD_HIGH:   btn_d = 1'b1;
            BOUNCE_FALL: btn_d = phase_q;
            SETTLE_FALL: btn_d = 1'b0;
            default:     btn_d = 1'b0;
        endcase
        busy_d = (state_q inside {BOUNCE_RISE, SETTLE_RISE, BOUNCE_FALL, SETTLE_FALL});
        // done_o is asserted in the same cycle that busy_o drops.
        done_d = busy_q & ~busy_d;
        // A release keeps held_o high until its settle period completes.
        held_d = (state_q inside {HELD_HIGH, BOUNCE_FALL, SETTLE_FALL});
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE_LOW;
            seg_cnt_q    <= '0;
            pair_cnt_q   <= '0;
            phase_q      <= 1'b0;
            settle_cnt_q <= '0;
            btn_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            held_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            seg_cnt_q    <= seg_cnt_d;
            pair_cnt_q   <= pair_cnt_d;
            phase_q      <= phase_d;
            settle_cnt_q <= settle_cnt_d;
            btn_q        <= btn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            held_q       <= held_d;
        end
    end

    assign btn_o  = btn_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign held_o = held_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// -----------------------------------------------------------------------------
// tb_button_bounce_gen
//
// Drives press/release/reset stimulus, using directed steps first and then
// random steps. A reference model accepts each request using the settled-level
// and completion-cycle rules. For every accepted request it pushes a sequence
// record (start edge, direction, segment widths, done cycle) onto a
// scoreboard queue. An independent monitor checks every cycle at the falling
// edge: it derives the expected btn/busy/done/held from the queue head and
// pops that head when the done cycle arrives.
// -----------------------------------------------------------------------------
module tb_button_bounce_gen;

    localparam int          BC   = 2;
    localparam int          GW   = 3;
    localparam int          GB   = 5;
    localparam int          SC   = 5;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          NSEG = 2 * BC;

    typedef struct packed {
        logic [31:0]           start;     // edge that accepted the request
        logic                  rise;
        logic [31:0]           done_cyc;  // cycle in which done must pulse
        logic [NSEG-1:0][5:0]  w;         // segment widths
    } seq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic press = 1'b0;
    logic release_r = 1'b0;
    logic btn, busy, done, held;

    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    seq_t exp_q[$];

    // Reference model state
    logic        m_held = 1'b0;
    int          m_last_done = 0;
    logic [15:0] m_lfsr = SEED;

    // Monitor state
    logic mon_held = 1'b0;

    button_bounce_gen #(
        .BOUNCE_COUNT (BC),
        .GLITCH_W     (GW),
        .GLITCH_BITS  (GB),
        .SETTLE_CYCLES(SC),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .press_req_i  (press),
        .release_req_i(release_r),
        .btn_o        (btn),
        .busy_o       (busy),
        .done_o       (done),
        .held_o       (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int seg_width();
`ifdef BOUNCE_RANDOM_EN
        logic fb;
        fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
        m_lfsr = {m_lfsr[14:0], fb};
        return int'(m_lfsr % (16'd1 << GB)) + 1;
`else
        return GW;
`endif
    endfunction

    // Expected btn level in cycle c: alternate the level per segment, then hold the target level.
    function automatic logic exp_btn(seq_t s, int c);
        int t;
        int acc;
        t   = c - int'(s.start);
        acc = 0;
        for (int i = 0; i < NSEG; i++) begin
            acc += int'(s.w[i]);
            if (t <= acc) return (i % 2 == 0) ? s.rise : ~s.rise;
        end
        return s.rise;
    endfunction

    task automatic check(input string name, input int cyc, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // One stimulus cycle: drive just after an edge; the model decides acceptance at the next edge.
    task automatic drive_cycle(input logic p, input logic r, input logic rs);
        int   k;
        seq_t s;
        int   sum;
        @(posedge clk);
        #2;
        rst       = rs;
        press     = p;
        release_r = r;
        k = edge_cnt + 1;
        if (rs) begin
            exp_q.delete();
            m_held      = 1'b0;
            m_last_done = 0;
            m_lfsr      = SEED;
            $display("cycle %0d: reset", edge_cnt);
        end else if (k >= m_last_done && ((!m_held && p) || (m_held && r))) begin
            s.rise  = ~m_held;
            s.start = 32'(k);
            sum = 0;
            for (int i = 0; i < NSEG; i++) begin
                s.w[i] = 6'(seg_width());
                sum += int'(s.w[i]);
            end
            s.done_cyc  = 32'(k + sum + SC + 1);
            m_last_done = k + sum + SC + 1;
            m_held      = s.rise;
            exp_q.push_back(s);
            $display("edge %0d: %s accepted, done expected at cycle %0d",
                     k, s.rise ? "press" : "release", m_last_done);
        end
    endtask

    // Monitor: compares outputs once per cycle at the falling edge.
    always @(negedge clk) begin
        int   c;
        seq_t s;
        c = edge_cnt;
        if (rst) begin
            check("reset_btn",  c, btn,  1'b0);
            check("reset_busy", c, busy, 1'b0);
            check("reset_done", c, done, 1'b0);
            check("reset_held", c, held, 1'b0);
            mon_held = 1'b0;
        end else if (exp_q.size() > 0 && c > int'(exp_q[0].start)) begin
            s = exp_q[0];
            if (c == int'(s.done_cyc)) begin
                check("done_pulse", c, done, 1'b1);
                check("done_busy",  c, busy, 1'b0);
                check("done_held",  c, held, s.rise);
                check("done_btn",   c, btn,  s.rise);
                mon_held = s.rise;
                void'(exp_q.pop_front());
                $display("cycle %0d: sequence %s completed", c, s.rise ? "rise" : "fall");
            end else begin
                check("seq_btn",  c, btn,  exp_btn(s, c));
                check("seq_busy", c, busy, 1'b1);
                check("seq_done", c, done, 1'b0);
                check("seq_held", c, held, ~s.rise);
            end
        end else begin
            check("idle_btn",  c, btn,  mon_held);
            check("idle_busy", c, busy, 1'b0);
            check("idle_done", c, done, 1'b0);
            check("idle_held", c, held, mon_held);
        end
    end

    initial begin
        // Reset, then press in the same step as the reset release.
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0);
        // Requests during the rise are ignored, including a simultaneous pair.
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0);
        repeat (20) drive_cycle(1'b0, 1'b0, 1'b0);
        // Release from HELD_HIGH; a simultaneous press is ignored.
        drive_cycle(1'b1, 1'b1, 1'b0);
        repeat (20) drive_cycle(1'b0, 1'b0, 1'b0);
        // A release in IDLE_LOW is ignored, then a press is interrupted by a reset mid-bounce.
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        repeat (7) drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0);
        repeat (20) drive_cycle(1'b0, 1'b0, 1'b0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic rs, p, r;
            rs = ($urandom_range(0, 599) == 0);
            p  = !rs && ($urandom_range(0, 7) == 0);
            r  = !rs && ($urandom_range(0, 7) == 0);
            drive_cycle(p, r, rs);
        end
        repeat (120) drive_cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_bounce_gen.md
BUTTON_BOUNCE_GEN -- requirements
Module: button_bounce_gen

Interface
REQ-001 Parameter BOUNCE_COUNT, default 6, number of glitch pairs per edge (legal 1..15).
REQ-002 Parameter GLITCH_W, default 3, fixed glitch segment width in clk cycles (legal 1..31).
REQ-003 Parameter GLITCH_BITS, default 5, LFSR bits used for random segment width.
REQ-004 Parameter SETTLE_CYCLES, default 2000, stable cycles after the last glitch (legal 1..16383).
REQ-005 Parameter LFSR_SEED, default 16'hACE1, reset value of the LFSR (nonzero).
REQ-006 clk  input  1  system clock, 48.8 kHz, all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 press_req  input  1  one-cycle request to emit a bouncy press.
REQ-009 release_req  input  1  one-cycle request to emit a bouncy release.
REQ-010 btn  output  1  registered emulated raw button level, drives a debouncer BTN input.
REQ-011 busy  output  1  high while an edge sequence is in progress.
REQ-012 done  output  1  one-cycle pulse when a sequence completes.
REQ-013 held  output  1  settled button level: 0 released, 1 pressed.

Function
REQ-014 States: IDLE_LOW, BOUNCE_RISE, SETTLE_RISE, HELD_HIGH, BOUNCE_FALL, SETTLE_FALL.
- IDLE_LOW: press_req -> BOUNCE_RISE; release_req ignored.
- HELD_HIGH: release_req -> BOUNCE_FALL; press_req ignored.
- Any request outside IDLE_LOW/HELD_HIGH ignored; no queuing.
REQ-015 Bounce phase emits 2*BOUNCE_COUNT segments alternating target level, non-target level; first segment at target level.
- Target level is 1 for a rise and 0 for a fall.
REQ-016 Segment width is W cycles, set as defined under Configuration.
REQ-017 btn changes one cycle after the accepting edge: request sampled at edge k gives the first segment at btn from cycle k+1.
REQ-018 After the last segment, the SETTLE state holds btn at the target level for SETTLE_CYCLES cycles.
REQ-019 At the end of settle:
- done pulses for exactly one cycle, the same cycle busy falls.
- held updates to the target level.
- Next state is HELD_HIGH (rise) or IDLE_LOW (fall).
REQ-020 busy=1 in all BOUNCE and SETTLE states, else 0; held is constant during busy.
REQ-021 Simultaneous press_req and release_req: only the request legal for the current state is accepted.
REQ-022 Segment counter 5 bits, settle counter 14 bits, glitch-pair counter 4 bits; no counter wraps within a legal configuration.

Reset
REQ-023 reset forces IDLE_LOW, btn=0, busy=0, done=0, held=0, counters=0, LFSR=LFSR_SEED, immediately and asynchronously, including mid-sequence.
REQ-024 First request is accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-025 Macro BOUNCE_RANDOM_EN.
- Defined: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, advances once per segment start; W = LFSR[GLITCH_BITS-1:0] + 1 (1..32).
- Undefined: no LFSR logic is compiled in, and W = GLITCH_W for every segment.
- All state, settle and handshake behaviour is identical with and without the macro.

Verification
REQ-026 Fixed width, BOUNCE_COUNT=2, GLITCH_W=3, SETTLE_CYCLES=5; press_req at edge 0 -> expected response:
- btn 1 in cycles 1-3, 0 in 4-6, 1 in 7-9, 0 in 10-12, then 1 from cycle 13.
- done pulses at cycle 18; held=1 from cycle 18; busy high cycles 1-17.
REQ-027 Same configuration; release_req from HELD_HIGH -> mirrored waveform (0,1,0,1 segments of 3 cycles), then btn=0; done at cycle 18; held=0.
REQ-028 press_req during BOUNCE_RISE, and release_req in IDLE_LOW -> both ignored; waveform identical to REQ-026.
REQ-029 reset asserted at cycle 8 of a rise -> btn=0, busy=0, held=0 within the same cycle; a later press_req replays the REQ-026 waveform exactly.
REQ-030 BOUNCE_RANDOM_EN defined, seed 16'hACE1 -> segment widths match a reference LFSR model, all widths lie in 1..32, and two runs after reset are identical.
REQ-031 Drive btn into the team debouncer (counterMAX=5), default fixed configuration -> debouncer emits exactly one clean pulse per press sequence.
